dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the pipeline's data port. It accepts the load and store requests the MEM stage drives: address, write data and a pre-shifted 4-bit byte enable. It completes each request after a fixed, parameterised latency with a one-cycle `mem_resp` pulse, returning read data on loads. It sits behind the MEM stage as the data-memory model and bench target, and wraps a byte-writable word array.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: word-address bits; depth is 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 2: cycles from request acceptance to `mem_resp`. Legal range is 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  load request; held stable until `mem_resp`.
- `mem_write`  in  1  store request; held stable until `mem_resp`.
- `mem_address`  in  32  byte address. Bits [1:0] are ignored; bits [ADDR_WIDTH+1:2] select the word.
- `mem_wdata`  in  32  store data, already lane-aligned.
- `mem_byte_enable`  in  4  per-byte write strobes, already shifted by address[1:0].
- `mem_rdata`  out  32  load data; valid while `mem_resp`=1 for a read.
- `mem_resp`  out  1  one-cycle completion pulse.

## Operation
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - If `mem_read` or `mem_write` is high, latch address, wdata, byte enable and op.
  - Go to RESP if LATENCY=1; otherwise go to BUSY with `cnt`=LATENCY-2.
  - Inputs after acceptance are not re-sampled.
- BUSY: decrement `cnt`; go to RESP when `cnt`=0.
- Entering RESP (same edge):
  - Write: each byte lane i with enable[i]=1 takes wdata[8i+7:8i]; disabled lanes keep their old value.
  - Read: `mem_rdata` is loaded with the addressed word.
- RESP: `mem_resp`=1 for exactly one cycle, then unconditionally IDLE.
- Both `mem_read` and `mem_write` high: treated as a write. `mem_rdata` is not updated.
- Write with byte enable 0000: completes normally and the array is unchanged.
- Addresses above the depth alias, because upper bits are dropped. There is no error.
- `mem_rdata` holds its last read value across writes and idle cycles.
- Reset:
  - State goes to IDLE, `mem_resp`=0, `mem_rdata`=0, `cnt`=0.
  - Array contents are not reset.
  - A reset during BUSY aborts the transaction with no array write. An abort in RESP leaves the already-committed write in place.

## Timing
- A request first high in cycle 0, with the FSM in IDLE, gives `mem_resp` high in cycle LATENCY.
- The requester drops or changes its request in the cycle after `mem_resp`. IDLE then samples the new request in that cycle, so back-to-back throughput is one request per LATENCY+1 cycles.
- Read-after-write to the same word with back-to-back requests returns the written data.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Reset assertion is immediate; deassertion is synchronous to `clk` through the normal flop path.

## Structure
- `dmem_state_t` (IDLE/BUSY/RESP enum) goes into `rv32i_types`, next to `rv32i_word`.
- Sub-module `dmem_array`: a 2^ADDR_WIDTH x 32 array with a synchronous per-byte write and a synchronous registered read, instantiated once.
- The top level holds the FSM, latency counter and request latches.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 with enable 1111; read 0x10. Required: the read's `mem_resp` arrives in cycle 2 after the request and `mem_rdata`=0xDEADBEEF.
- After the above, write 0x00AA0000 to 0x12 with enable 0100; read 0x10. Required: 0xDEAABEEF.
- LATENCY=1 and LATENCY=5 builds. Required: `mem_resp` in cycle 1 and cycle 5 respectively, pulse exactly 1 cycle, a new request accepted in the following cycle.
- `mem_read` and `mem_write` both high with wdata 0x12345678 to 0x20. Required: the array holds the new value and `mem_rdata` keeps its prior value.
- Assert `reset_n`=0 during BUSY of a write to 0x30 holding 0x11111111 with wdata 0x22222222. Required: `mem_resp` never pulses, a subsequent read returns 0x11111111, and outputs are 0 during reset.
- Address 0x400 with ADDR_WIDTH=8. Required: aliases to word 0, so a write there is readable at address 0x0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types used by the pipeline and its memory models.
// Holds the data-word type and the data-memory responder FSM states.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Byte-writable word array with a registered read port.
// Read data holds until the next read; only the read register is reset.
import rv32i_types::*;

module dmem_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            be_i,
    output logic [31:0]           rdata_o
);

    rv32i_word mem_q [2**ADDR_WIDTH];
    rv32i_word rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, completes it after
// LATENCY cycles with a single-cycle mem_resp pulse.
import rv32i_types::*;

module dmem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_rdata,
    output logic        mem_resp
);

    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dmem_state_t           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    rv32i_word             wdata_q;
    logic [3:0]            be_q;
    logic                  wr_q;

    logic                  req, accept, commit;
    logic [ADDR_WIDTH-1:0] addr_c;
    rv32i_word             wdata_c;
    logic [3:0]            be_c;
    logic                  wr_c;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};

    assign req    = mem_read | mem_write;
    assign accept = (state_q == IDLE) & req;
    assign commit = (state_d == RESP) & (state_q != RESP);

    // With LATENCY=1 the commit edge is the accept edge, so use live inputs.
    assign addr_c  = (state_q == IDLE) ? mem_address[ADDR_WIDTH+1:2] : addr_q;
    assign wdata_c = (state_q == IDLE) ? mem_wdata : wdata_q;
    assign be_c    = (state_q == IDLE) ? mem_byte_enable : be_q;
    assign wr_c    = (state_q == IDLE) ? mem_write : wr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= mem_address[ADDR_WIDTH+1:2];
                wdata_q <= mem_wdata;
                be_q    <= mem_byte_enable;
                wr_q    <= mem_write;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else cnt_d = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_resp = (state_q == RESP);
    end

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .we_i   (commit & wr_c),
        .re_i   (commit & ~wr_c),
        .addr_i (addr_c),
        .wdata_i(wdata_c),
        .be_i   (be_c),
        .rdata_o(mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array model,
// plus LATENCY=1 and LATENCY=5 timing instances.
module tb_dmem_responder;

    localparam int AW  = 8;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        resp;

    logic        a_rd, a_wr, b_rd, b_wr;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [3:0]  a_be, b_be;
    logic [31:0] a_rdata, b_rdata;
    logic        a_resp, b_resp;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_mem [2**AW];
    logic [31:0] model_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_read(rd), .mem_write(wr),
        .mem_address(addr), .mem_wdata(wdata),
        .mem_byte_enable(be),
        .mem_rdata(rdata), .mem_resp(resp)
    );

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset_n(reset_n),
        .mem_read(a_rd), .mem_write(a_wr),
        .mem_address(a_addr), .mem_wdata(a_wdata),
        .mem_byte_enable(a_be),
        .mem_rdata(a_rdata), .mem_resp(a_resp)
    );

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(5)) dut_l5 (
        .clk(clk), .reset_n(reset_n),
        .mem_read(b_rd), .mem_write(b_wr),
        .mem_address(b_addr), .mem_wdata(b_wdata),
        .mem_byte_enable(b_be),
        .mem_rdata(b_rdata), .mem_resp(b_resp)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic void model_apply(input logic r, input logic w,
                                        input logic [31:0] a,
                                        input logic [31:0] d,
                                        input logic [3:0] e);
        int idx;
        idx = int'(a / 4) % (2**AW);
        if (w) begin
            for (int i = 0; i < 4; i++)
                if (e[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
        end else if (r) begin
            model_rdata = model_mem[idx];
        end
    endfunction

    // Called in cycle 0 (just after a rising edge, DUT idle); returns in
    // the cycle after mem_resp with the request dropped.
    task automatic do_req(input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] e);
        int lat;
        rd = r; wr = w; addr = a; wdata = d; be = e;
        model_apply(r, w, a, d, e);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (resp) begin
                lat = c;
                break;
            end
        end
        check("latency", 32'(lat), 32'(LAT));
        check("rdata", rdata, model_rdata);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        check("pulse_width", {31'd0, resp}, 32'd0);
    endtask

    task automatic lat_test(input bit sel5, input int lat_exp);
        int c1, c2;
        logic r;
        if (sel5) begin
            b_wr = 1; b_addr = 32'h44; b_wdata = 32'hCAFE0005; b_be = 4'hF;
        end else begin
            a_wr = 1; a_addr = 32'h44; a_wdata = 32'hCAFE0001; a_be = 4'hF;
        end
        c1 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            r = sel5 ? b_resp : a_resp;
            if (r) begin c1 = c; break; end
        end
        check(sel5 ? "l5_latency" : "l1_latency", 32'(c1), 32'(lat_exp));
        @(posedge clk); #1;
        r = sel5 ? b_resp : a_resp;
        check(sel5 ? "l5_pulse" : "l1_pulse", {31'd0, r}, 32'd0);
        if (sel5) begin b_wr = 0; b_rd = 1; end
        else begin a_wr = 0; a_rd = 1; end
        c2 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            r = sel5 ? b_resp : a_resp;
            if (r) begin c2 = c; break; end
        end
        check(sel5 ? "l5_b2b" : "l1_b2b", 32'(c2), 32'(lat_exp));
        check(sel5 ? "l5_rdata" : "l1_rdata",
              sel5 ? b_rdata : a_rdata,
              sel5 ? 32'hCAFE0005 : 32'hCAFE0001);
        @(posedge clk); #1;
        a_rd = 0; b_rd = 0;
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] ra;
        int          pulses;

        rd = 0; wr = 0; addr = 0; wdata = 0; be = 0;
        a_rd = 0; a_wr = 0; a_addr = 0; a_wdata = 0; a_be = 0;
        b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0; b_be = 0;
        model_rdata = 32'd0;
        reset_n = 1'b0;
        #1;
        check("reset_resp", {31'd0, resp}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 2**AW; i++)
            do_req(0, 1, 32'(i * 4), $urandom, 4'hF);

        do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(1, 0, 32'h10, 32'h0, 4'h0);
        check("deadbeef", rdata, 32'hDEADBEEF);
        do_req(0, 1, 32'h12, 32'h00AA0000, 4'b0100);
        do_req(1, 0, 32'h10, 32'h0, 4'h0);
        check("byte_lane", rdata, 32'hDEAABEEF);
        do_req(0, 1, 32'h10, 32'h55555555, 4'h0);
        do_req(1, 0, 32'h10, 32'h0, 4'h0);
        check("be_zero", rdata, 32'hDEAABEEF);

        do_req(1, 1, 32'h20, 32'h12345678, 4'hF);
        check("both_keep", rdata, 32'hDEAABEEF);
        do_req(1, 0, 32'h20, 32'h0, 4'h0);
        check("both_write", rdata, 32'h12345678);

        do_req(0, 1, 32'h400, 32'hA5A5F00D, 4'hF);
        do_req(1, 0, 32'h0, 32'h0, 4'h0);
        check("alias", rdata, 32'hA5A5F00D);

        do_req(0, 1, 32'h30, 32'h11111111, 4'hF);
        rd = 0; wr = 1; addr = 32'h30; wdata = 32'h22222222; be = 4'hF;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("abort_resp", {31'd0, resp}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        wr = 0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        model_rdata = 32'd0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (resp) pulses++;
        end
        check("abort_no_resp", 32'(pulses), 32'd0);
        do_req(1, 0, 32'h30, 32'h0, 4'h0);
        check("abort_no_write", rdata, 32'h11111111);

        for (int n = 0; n < 300; n++) begin
            op = 2'($urandom_range(0, 2));
            ra = $urandom;
            do_req(op != 2'd1, op != 2'd0, ra, $urandom, 4'($urandom));
        end

        lat_test(1'b0, 1);
        lat_test(1'b1, 5);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
